// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 set-2 scan-code constants, decoder FSM state codes and byte classification helpers.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PFX_E0    = 8'hE0;
    localparam logic [7:0] PFX_F0    = 8'hF0;
    localparam logic [7:0] PFX_E1    = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Keyboard-to-host control bytes that never denote a key
    localparam logic [7:0] BYTE_ERR0     = 8'h00;
    localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0] BYTE_ECHO     = 8'hEE;
    localparam logic [7:0] BYTE_ACK      = 8'hFA;
    localparam logic [7:0] BYTE_BAT_FAIL = 8'hFC;
    localparam logic [7:0] BYTE_RESEND   = 8'hFE;
    localparam logic [7:0] BYTE_ERR1     = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == BYTE_ERR0)   || (b == BYTE_BAT_OK)   || (b == BYTE_ECHO) ||
               (b == BYTE_ACK)    || (b == BYTE_BAT_FAIL) || (b == BYTE_RESEND) ||
               (b == BYTE_ERR1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PFX_E0) || (b == PFX_F0);
    endfunction

endpackage

// File: rtl/ps2_scan_ascii.sv
// Combinational set-2 scan-code to ASCII translation: 128-entry {lower, upper} ROM plus
// the shift / caps-lock / ctrl selection applied to it.
module ps2_scan_ascii
    import ps2_key_decoder_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    input  logic       ctrl,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [15:0] rom_word;
    logic [7:0]  lower;
    logic [7:0]  upper;
    logic        is_letter;

    always_comb begin
        rom_word = 16'h0000;
        case (code[6:0])
            7'h1C: rom_word = {8'h61, 8'h41};
            7'h32: rom_word = {8'h62, 8'h42};
            7'h21: rom_word = {8'h63, 8'h43};
            7'h23: rom_word = {8'h64, 8'h44};
            7'h24: rom_word = {8'h65, 8'h45};
            7'h2B: rom_word = {8'h66, 8'h46};
            7'h34: rom_word = {8'h67, 8'h47};
            7'h33: rom_word = {8'h68, 8'h48};
            7'h43: rom_word = {8'h69, 8'h49};
            7'h3B: rom_word = {8'h6A, 8'h4A};
            7'h42: rom_word = {8'h6B, 8'h4B};
            7'h4B: rom_word = {8'h6C, 8'h4C};
            7'h3A: rom_word = {8'h6D, 8'h4D};
            7'h31: rom_word = {8'h6E, 8'h4E};
            7'h44: rom_word = {8'h6F, 8'h4F};
            7'h4D: rom_word = {8'h70, 8'h50};
            7'h15: rom_word = {8'h71, 8'h51};
            7'h2D: rom_word = {8'h72, 8'h52};
            7'h1B: rom_word = {8'h73, 8'h53};
            7'h2C: rom_word = {8'h74, 8'h54};
            7'h3C: rom_word = {8'h75, 8'h55};
            7'h2A: rom_word = {8'h76, 8'h56};
            7'h1D: rom_word = {8'h77, 8'h57};
            7'h22: rom_word = {8'h78, 8'h58};
            7'h35: rom_word = {8'h79, 8'h59};
            7'h1A: rom_word = {8'h7A, 8'h5A};
            7'h16: rom_word = {8'h31, 8'h21};
            7'h1E: rom_word = {8'h32, 8'h40};
            7'h26: rom_word = {8'h33, 8'h23};
            7'h25: rom_word = {8'h34, 8'h24};
            7'h2E: rom_word = {8'h35, 8'h25};
            7'h36: rom_word = {8'h36, 8'h5E};
            7'h3D: rom_word = {8'h37, 8'h26};
            7'h3E: rom_word = {8'h38, 8'h2A};
            7'h46: rom_word = {8'h39, 8'h28};
            7'h45: rom_word = {8'h30, 8'h29};
            7'h0E: rom_word = {8'h60, 8'h7E};
            7'h4E: rom_word = {8'h2D, 8'h5F};
            7'h55: rom_word = {8'h3D, 8'h2B};
            7'h54: rom_word = {8'h5B, 8'h7B};
            7'h5B: rom_word = {8'h5D, 8'h7D};
            7'h5D: rom_word = {8'h5C, 8'h7C};
            7'h4C: rom_word = {8'h3B, 8'h3A};
            7'h52: rom_word = {8'h27, 8'h22};
            7'h41: rom_word = {8'h2C, 8'h3C};
            7'h49: rom_word = {8'h2E, 8'h3E};
            7'h4A: rom_word = {8'h2F, 8'h3F};
            7'h29: rom_word = {8'h20, 8'h20};
            7'h5A: rom_word = {8'h0D, 8'h0D};
            7'h66: rom_word = {8'h08, 8'h08};
            7'h0D: rom_word = {8'h09, 8'h09};
            7'h76: rom_word = {8'h1B, 8'h1B};
            default: rom_word = 16'h0000;
        endcase
    end

    assign lower     = rom_word[15:8];
    assign upper     = rom_word[7:0];
    assign is_letter = (lower >= 8'h61) && (lower <= 8'h7A);

    // Letters honour caps lock and ctrl; everything else follows shift only
    always_comb begin
        ascii = 8'h00;
        if (ext) begin
            ascii = (code == SC_ENTER) ? 8'h0D : 8'h00;
        end else if (code[7]) begin
            ascii = 8'h00;
        end else if (is_letter) begin
            if (ctrl)
                ascii = lower - 8'h60;
            else
                ascii = (shift ^ caps) ? upper : lower;
        end else begin
            ascii = shift ? upper : lower;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 set-2 scan-code bytes from the ps2_kbd FIFO into single key events with
// modifier tracking, presented to the CPU-side register through a valid/ack handshake.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter bit EMIT_BREAK = 1'b1,
    parameter int E1_SKIP    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_read,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] key_ascii,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       caps_lock
);

    state_t     state, state_nxt;
    logic [7:0] skip_cnt, skip_cnt_nxt;
    logic       pop;

    logic       ev_done_p0, ev_ext_p0, ev_brk_p0;
    logic       fake_shift_p0, take_p0, emit_p0;
    logic       shift_p0, ctrl_p0;
    logic [7:0] ascii_p0;

    logic       lshift, rshift, lctrl, rctrl, caps_held;
    logic       lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt, caps_held_nxt, caps_lock_nxt;

    // A held, unacknowledged event blocks the FIFO; ack frees the slot in the same cycle
    assign pop      = kbd_ready & (~key_valid | key_ack);
    assign kbd_read = pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        if (pop) begin
            case (state)
                ST_IDLE: begin
                    if (kbd_data == PFX_E0) begin
                        state_nxt = ST_EXT;
                    end else if (kbd_data == PFX_F0) begin
                        state_nxt = ST_BRK;
                    end else if (kbd_data == PFX_E1 && E1_SKIP > 0) begin
                        state_nxt    = ST_SKIP;
                        skip_cnt_nxt = 8'(E1_SKIP);
                    end
                end
                ST_EXT: begin
                    if (kbd_data == PFX_F0)
                        state_nxt = ST_EXT_BRK;
                    else if (kbd_data != PFX_E0)
                        state_nxt = ST_IDLE;
                end
                ST_BRK: begin
                    if (kbd_data == PFX_E0)
                        state_nxt = ST_EXT_BRK;
                    else if (kbd_data != PFX_F0)
                        state_nxt = ST_IDLE;
                end
                ST_EXT_BRK: state_nxt = ST_IDLE;
                ST_SKIP: begin
                    skip_cnt_nxt = skip_cnt - 8'd1;
                    if (skip_cnt <= 8'd1)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_done_p0 = 1'b0;
        ev_ext_p0  = 1'b0;
        ev_brk_p0  = 1'b0;
        if (pop) begin
            case (state)
                ST_IDLE: ev_done_p0 = !is_prefix(kbd_data) && (kbd_data != PFX_E1) &&
                                      !is_ctrl_byte(kbd_data);
                ST_EXT: begin
                    ev_done_p0 = !is_prefix(kbd_data);
                    ev_ext_p0  = 1'b1;
                end
                ST_BRK: begin
                    ev_done_p0 = !is_prefix(kbd_data);
                    ev_brk_p0  = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev_done_p0 = 1'b1;
                    ev_ext_p0  = 1'b1;
                    ev_brk_p0  = 1'b1;
                end
                default: ev_done_p0 = 1'b0;
            endcase
        end
    end

    // E0 12 / E0 59 are the keyboard's synthetic shifts around extended keys
    assign fake_shift_p0 = ev_ext_p0 && (kbd_data == SC_LSHIFT || kbd_data == SC_RSHIFT);
    assign take_p0       = ev_done_p0 & ~fake_shift_p0;
    assign emit_p0       = take_p0 & (~ev_brk_p0 | EMIT_BREAK);

    always_comb begin
        lshift_nxt    = lshift;
        rshift_nxt    = rshift;
        lctrl_nxt     = lctrl;
        rctrl_nxt     = rctrl;
        caps_held_nxt = caps_held;
        caps_lock_nxt = caps_lock;
        if (take_p0 && !ev_ext_p0) begin
            case (kbd_data)
                SC_LSHIFT: lshift_nxt = !ev_brk_p0;
                SC_RSHIFT: rshift_nxt = !ev_brk_p0;
                SC_CTRL:   lctrl_nxt  = !ev_brk_p0;
                SC_CAPS: begin
                    if (!ev_brk_p0 && !caps_held)
                        caps_lock_nxt = !caps_lock;
                    caps_held_nxt = !ev_brk_p0;
                end
                default: ;
            endcase
        end
        if (take_p0 && ev_ext_p0 && kbd_data == SC_CTRL)
            rctrl_nxt = !ev_brk_p0;
    end

    // ASCII sees the modifier state that includes this very byte
    assign shift_p0 = lshift_nxt | rshift_nxt;
    assign ctrl_p0  = lctrl_nxt | rctrl_nxt;

    ps2_scan_ascii u_scan_ascii (
        .code  (kbd_data),
        .ext   (ev_ext_p0),
        .shift (shift_p0),
        .ctrl  (ctrl_p0),
        .caps  (caps_lock_nxt),
        .ascii (ascii_p0)
    );

    // p0 -> p1: event and modifier registers
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_break <= 1'b0;
            key_ascii <= 8'h00;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            lctrl     <= 1'b0;
            rctrl     <= 1'b0;
            caps_held <= 1'b0;
            caps_lock <= 1'b0;
        end else begin
            lshift    <= lshift_nxt;
            rshift    <= rshift_nxt;
            lctrl     <= lctrl_nxt;
            rctrl     <= rctrl_nxt;
            caps_held <= caps_held_nxt;
            caps_lock <= caps_lock_nxt;
            if (emit_p0) begin
                key_valid <= 1'b1;
                key_code  <= kbd_data;
                key_ext   <= ev_ext_p0;
                key_break <= ev_brk_p0;
                key_ascii <= ascii_p0;
            end else if (key_ack) begin
                key_valid <= 1'b0;
            end
        end
    end

    assign mod_shift = lshift | rshift;
    assign mod_ctrl  = lctrl | rctrl;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: FIFO stand-in, behavioural key-event model, directed vector
// table, handshake corner cases and a randomized byte stream.
module tb_ps2_key_decoder;

  localparam bit EMIT_BREAK = 1'b1;
  localparam int E1_SKIP    = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_ready = 1'b0;
  logic       kbd_read;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic       mod_shift;
  logic       mod_ctrl;
  logic       caps_lock;

  always #5 clk = ~clk;

  ps2_key_decoder #(.EMIT_BREAK(EMIT_BREAK), .E1_SKIP(E1_SKIP)) dut (
    .clk       (clk),
    .rst       (rst),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .kbd_read  (kbd_read),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_ascii (key_ascii),
    .mod_shift (mod_shift),
    .mod_ctrl  (mod_ctrl),
    .caps_lock (caps_lock)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic       shift;
    logic       ctrl;
    logic       caps;
  } ev_t;

  typedef struct {
    logic [95:0] bytes;
    int          n;
    int          n_ev;
    ev_t         last;
  } vec_t;

  logic [7:0] fifo[$];
  ev_t        exp_q[$];
  ev_t        obs_q[$];
  vec_t       vecs[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ack_mode = 1;
  bit         exp_valid;

  logic [7:0] lo_tab[256];
  logic [7:0] up_tab[256];
  bit         held[512];
  bit         m_ext, m_brk, m_caps;
  int         m_skip;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk_ev(logic [7:0] c, bit e, bit b, logic [7:0] a, bit s, bit ct, bit k);
    ev_t r;
    r = '{code: c, ext: e, brk: b, ascii: a, shift: s, ctrl: ct, caps: k};
    return r;
  endfunction

  function automatic void init_tables();
    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes[10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
      8'h3E, 8'h46, 8'h45};
    logic [7:0] punct_codes[11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
      8'h52, 8'h41, 8'h49, 8'h4A};
    logic [7:0] pun_lo[11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B,
      8'h27, 8'h2C, 8'h2E, 8'h2F};
    logic [7:0] pun_up[11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A,
      8'h22, 8'h3C, 8'h3E, 8'h3F};
    string dig_lo = "1234567890";
    string dig_up = "!@#$%^&*()";
    for (int i = 0; i < 256; i++) begin
      lo_tab[i] = 8'h00;
      up_tab[i] = 8'h00;
    end
    for (int i = 0; i < 26; i++) begin
      lo_tab[letter_codes[i]] = 8'(8'h61 + i);
      up_tab[letter_codes[i]] = 8'(8'h41 + i);
    end
    for (int i = 0; i < 10; i++) begin
      lo_tab[digit_codes[i]] = dig_lo[i];
      up_tab[digit_codes[i]] = dig_up[i];
    end
    for (int i = 0; i < 11; i++) begin
      lo_tab[punct_codes[i]] = pun_lo[i];
      up_tab[punct_codes[i]] = pun_up[i];
    end
    lo_tab[8'h29] = 8'h20; up_tab[8'h29] = 8'h20;
    lo_tab[8'h5A] = 8'h0D; up_tab[8'h5A] = 8'h0D;
    lo_tab[8'h66] = 8'h08; up_tab[8'h66] = 8'h08;
    lo_tab[8'h0D] = 8'h09; up_tab[8'h0D] = 8'h09;
    lo_tab[8'h76] = 8'h1B; up_tab[8'h76] = 8'h1B;
  endfunction

  function automatic logic [7:0] model_ascii(logic [7:0] c, bit e, bit sh, bit ct, bit cp);
    logic [7:0] l;
    if (e) return (c == 8'h5A) ? 8'h0D : 8'h00;
    l = lo_tab[c];
    if (l >= 8'h61 && l <= 8'h7A) begin
      if (ct) return l - 8'h60;
      return (sh ^ cp) ? up_tab[c] : l;
    end
    return sh ? up_tab[c] : l;
  endfunction

  // Consumes one popped byte; returns 1 when it completes a presented event
  function automatic bit model_byte(logic [7:0] b);
    bit e, k, sh, ct;
    if (m_skip > 0) begin
      m_skip--;
      return 0;
    end
    if (!m_ext && !m_brk) begin
      if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) return 0;
      if (b == 8'hE1) begin
        m_skip = E1_SKIP;
        return 0;
      end
    end
    if (!(m_ext && m_brk) && (b == 8'hE0 || b == 8'hF0)) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else            m_brk = 1'b1;
      return 0;
    end
    e = m_ext;
    k = m_brk;
    m_ext = 1'b0;
    m_brk = 1'b0;
    if (e && (b == 8'h12 || b == 8'h59)) return 0;
    if (!e && !k && b == 8'h58 && !held[9'h058]) m_caps = !m_caps;
    held[{e, b}] = !k;
    if (k && !EMIT_BREAK) return 0;
    sh = held[9'h012] | held[9'h059];
    ct = held[9'h014] | held[9'h114];
    exp_q.push_back(mk_ev(b, e, k, model_ascii(b, e, sh, ct, m_caps), sh, ct, m_caps));
    return 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    kbd_ready = 1'b0;
    kbd_data = 8'h00;
    key_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fifo.delete();
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    m_ext = 0; m_brk = 0; m_caps = 0; m_skip = 0;
    exp_valid = 1'b0;
    #1;
    check("reset_outputs", {key_valid, key_code, key_ext, key_break, key_ascii,
                            mod_shift, mod_ctrl, caps_lock, kbd_read}, 32'd0);
  endtask

  task automatic cycle();
    bit ack, rd, emitted;
    ev_t cur;
    @(negedge clk);
    kbd_ready = (fifo.size() > 0);
    kbd_data  = kbd_ready ? fifo[0] : 8'h00;
    case (ack_mode)
      0: ack = 1'b0;
      1: ack = 1'b1;
      default: ack = 1'($urandom_range(0, 1));
    endcase
    key_ack = ack;
    #1;
    check("key_valid", key_valid, exp_valid);
    check("kbd_read", kbd_read, kbd_ready & (~exp_valid | ack));
    if (key_valid && ack) begin
      cur = mk_ev(key_code, key_ext, key_break, key_ascii, mod_shift, mod_ctrl, caps_lock);
      obs_q.push_back(cur);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none", cur);
      end else begin
        check("event", cur, exp_q.pop_front());
      end
    end
    rd = kbd_read;
    emitted = 1'b0;
    if (rd && fifo.size() > 0) emitted = model_byte(fifo.pop_front());
    if (emitted)               exp_valid = 1'b1;
    else if (exp_valid && ack) exp_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain(input int max_cyc);
    int c = 0;
    while ((fifo.size() > 0 || exp_valid || key_valid) && c < max_cyc) begin
      cycle();
      c++;
    end
    if (c >= max_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, fifo %0d", c, fifo.size());
    end
  endtask

  task automatic add_vec(input logic [95:0] bytes, input int n, input int n_ev, input ev_t last);
    vec_t v;
    v.bytes = bytes;
    v.n = n;
    v.n_ev = n_ev;
    v.last = last;
    vecs.push_back(v);
  endtask

  task automatic push_token();
    logic [7:0] pool[16] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h45, 8'h4A, 8'h29, 8'h5A,
                             8'h12, 8'h59, 8'h14, 8'h58, 8'h0E, 8'h66, 8'h76, 8'h75};
    logic [7:0] drops[7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] c;
    int k;
    k = $urandom_range(0, 10);
    c = pool[$urandom_range(0, 15)];
    case (k)
      0, 1, 2, 3: fifo.push_back(c);
      4, 5: begin fifo.push_back(8'hF0); fifo.push_back(c); end
      6: begin fifo.push_back(8'hE0); fifo.push_back(c); end
      7: begin fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(c); end
      8: fifo.push_back(drops[$urandom_range(0, 6)]);
      9: begin
        fifo.push_back(8'hE1);
        for (int i = 0; i < 7; i++) fifo.push_back(pool[$urandom_range(0, 15)]);
      end
      default: fifo.push_back(8'($urandom_range(0, 255)));
    endcase
  endtask

  initial begin
    vec_t v;
    init_tables();

    add_vec(96'h1C,                 1, 1, mk_ev(8'h1C, 0, 0, 8'h61, 0, 0, 0));
    add_vec(96'h121C,               2, 2, mk_ev(8'h1C, 0, 0, 8'h41, 1, 0, 0));
    add_vec(96'h121CF01C,           4, 3, mk_ev(8'h1C, 0, 1, 8'h41, 1, 0, 0));
    add_vec(96'h121CF01CF012,       6, 4, mk_ev(8'h12, 0, 1, 8'h00, 0, 0, 0));
    add_vec(96'h5858,               2, 2, mk_ev(8'h58, 0, 0, 8'h00, 0, 0, 1));
    add_vec(96'h5858F0581C,         5, 4, mk_ev(8'h1C, 0, 0, 8'h41, 0, 0, 1));
    add_vec(96'h58F05858,           4, 3, mk_ev(8'h58, 0, 0, 8'h00, 0, 0, 0));
    add_vec(96'hE075,               2, 1, mk_ev(8'h75, 1, 0, 8'h00, 0, 0, 0));
    add_vec(96'hE075E0F075,         5, 2, mk_ev(8'h75, 1, 1, 8'h00, 0, 0, 0));
    add_vec(96'hE11477E1F014F0771C, 9, 1, mk_ev(8'h1C, 0, 0, 8'h61, 0, 0, 0));
    add_vec(96'hE012E05A,           4, 1, mk_ev(8'h5A, 1, 0, 8'h0D, 0, 0, 0));
    add_vec(96'h141C,               2, 2, mk_ev(8'h1C, 0, 0, 8'h01, 0, 1, 0));
    add_vec(96'hAAFA1216,           4, 2, mk_ev(8'h16, 0, 0, 8'h21, 1, 0, 0));
    add_vec(96'hE014E0F014,         5, 2, mk_ev(8'h14, 1, 1, 8'h00, 0, 0, 0));
    add_vec(96'h594A,               2, 2, mk_ev(8'h4A, 0, 0, 8'h3F, 1, 0, 0));
    add_vec(96'h58121C,             3, 3, mk_ev(8'h1C, 0, 0, 8'h61, 1, 0, 1));
    add_vec(96'h0E,                 1, 1, mk_ev(8'h0E, 0, 0, 8'h60, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_reset();
      ack_mode = 1;
      for (int j = 0; j < v.n; j++) fifo.push_back(v.bytes[8*(v.n-1-j) +: 8]);
      drain(200);
      check($sformatf("vec%0d_events", i), obs_q.size(), v.n_ev);
      if (obs_q.size() > 0) check($sformatf("vec%0d_last", i), obs_q[$], v.last);
      check($sformatf("vec%0d_mods", i), {mod_shift, mod_ctrl, caps_lock},
            {v.last.shift, v.last.ctrl, v.last.caps});
    end

    // Backpressure, first-event latency and ack+pop in one cycle
    do_reset();
    ack_mode = 0;
    fifo = '{8'h1C, 8'h32, 8'h21};
    cycle();
    #1;
    check("latency_valid", key_valid, 1'b1);
    repeat (4) cycle();
    check("held_no_pop", fifo.size(), 2);
    check("held_code", key_code, 8'h1C);
    ack_mode = 1;
    cycle();
    #1;
    check("b2b_pop", fifo.size(), 1);
    check("b2b_valid", {key_valid, key_code}, {1'b1, 8'h32});
    drain(50);
    check("b2b_events", obs_q.size(), 3);

    // Reset after E0 discards the pending prefix
    do_reset();
    ack_mode = 1;
    fifo.push_back(8'hE0);
    cycle();
    do_reset();
    fifo.push_back(8'h1C);
    drain(50);
    check("rst_prefix_events", obs_q.size(), 1);
    if (obs_q.size() > 0) check("rst_prefix_event", {obs_q[0].code, obs_q[0].ext}, {8'h1C, 1'b0});

    // Randomized stream with random acks
    do_reset();
    ack_mode = 2;
    for (int t = 0; t < 400; t++) push_token();
    drain(20000);
    check("random_exp_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
